// File: rtl/elevator_pkg.sv
// elevator_pkg: shared types, direction codes and floor-mask helpers for the elevator controller.
// Latency: n/a (types and pure functions only).
// Backpressure: n/a.
// Contents: state_t {IDLE, MOVE, DOOR}, DIR_* codes, NUM_FLOORS, floor_t and 4-bit floor-mask helpers.
package elevator_pkg;

   localparam int NUM_FLOORS = 4;

   typedef logic [1:0] floor_t;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      MOVE = 2'd1,
      DOOR = 2'd2
   } state_t;

   localparam logic [1:0] DIR_IDLE = 2'b00;
   localparam logic [1:0] DIR_UP   = 2'b01;
   localparam logic [1:0] DIR_DOWN = 2'b10;

   // One bit per floor, bit 0 = floor 1.
   function automatic logic [NUM_FLOORS-1:0] floor_onehot(input floor_t f);
      logic [NUM_FLOORS-1:0] one;
      one = 4'b0001;
      return one << f;
   endfunction

   // Floors strictly above f.
   function automatic logic [NUM_FLOORS-1:0] above_mask(input floor_t f);
      logic [NUM_FLOORS-1:0] m;
      m = 4'b1110;
      return m << f;
   endfunction

   // Floors strictly below f.
   function automatic logic [NUM_FLOORS-1:0] below_mask(input floor_t f);
      return ~(above_mask(f) | floor_onehot(f));
   endfunction

endpackage

// File: rtl/elevator_request_latch.sv
// request_latch: bank of W independent set/clear request registers (one per call button).
// Latency: a set or clear takes effect on the next rising edge; clear wins over a same-cycle set.
// Backpressure: none; every set is accepted unless cleared in the same cycle.
// Ports: clk, rst (sync, active high), i_set[W], i_clr[W], o_q[W] registered request state.
module request_latch #(
   parameter int W = 10
) (
   input  logic         clk,
   input  logic         rst,
   input  logic [W-1:0] i_set,
   input  logic [W-1:0] i_clr,
   output logic [W-1:0] o_q
);

   logic [W-1:0] r_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_q <= '0;
      end else begin
         r_q <= (r_q | i_set) & ~i_clr;
      end
   end

   assign o_q = r_q;

endmodule

// File: rtl/elevator.sv
// elevator: single-car 4-floor controller, latched hall/car calls, collective (SCAN) scheduling.
// Latency: a call is latched one edge after it is sampled; floor-to-floor takes MOVE_CYCLES, a stop DOOR_CYCLES+1.
// Backpressure: none; buttons are level-sampled every cycle and all presses are accepted except at an open door.
// Ports: clk, rst (sync, active high); U1..U3 / D2..D4 hall buttons; F1..F4 car buttons;
//        *_led latched call indicators; Floor (0 = floor 1); Direction (00 idle, 01 up, 10 down);
//        door_open high while the door is open; Opened pulses on the cycle the door closes.
// Build option ELEVATOR_DOOR_REOPEN_EN: a button for the current floor while the door is open
//        restarts the door timer (default build: such presses are simply dropped).
module elevator
   import elevator_pkg::*;
#(
   parameter int MOVE_CYCLES = 4,
   parameter int DOOR_CYCLES = 3
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       U1,
   input  logic       U2,
   input  logic       U3,
   input  logic       D2,
   input  logic       D3,
   input  logic       D4,
   input  logic       F1,
   input  logic       F2,
   input  logic       F3,
   input  logic       F4,
   output logic       U1_led,
   output logic       U2_led,
   output logic       U3_led,
   output logic       D2_led,
   output logic       D3_led,
   output logic       D4_led,
   output logic       F1_led,
   output logic       F2_led,
   output logic       F3_led,
   output logic       F4_led,
   output logic [1:0] Floor,
   output logic [1:0] Direction,
   output logic       door_open,
   output logic       Opened
);

   localparam int MAXC = (MOVE_CYCLES > DOOR_CYCLES) ? MOVE_CYCLES : DOOR_CYCLES;
   localparam int CW   = $clog2(MAXC + 1);
   // MOVE counts 0..MOVE_CYCLES-1; DOOR counts 0..DOOR_CYCLES, the last value being the closing cycle.
   localparam logic [CW-1:0] MOVE_LAST = CW'(MOVE_CYCLES - 1);
   localparam logic [CW-1:0] DOOR_LAST = CW'(DOOR_CYCLES);

   state_t        r_state, w_state_nxt;
   floor_t        r_floor, w_floor_nxt;
   logic [1:0]    r_dir, w_dir_nxt;
   logic [CW-1:0] r_cnt, w_cnt_nxt;

   // Per-floor views, index = floor. Up has no floor 4, down has no floor 1.
   logic [3:0] w_btn_up, w_btn_dn, w_btn_car;
   logic [3:0] w_led_up, w_led_dn, w_led_car;
   logic [3:0] w_set_up, w_set_dn, w_set_car;
   logic [3:0] w_pend_up, w_pend_dn, w_pend_car, w_pend;
   logic [3:0] w_here, w_absorb, w_oh;
   logic [9:0] w_set, w_clr, w_q;

   logic   w_door_open;
   logic   w_above, w_below;
   floor_t w_nf, w_sf;
   logic   w_nf_ahead, w_nf_edge, w_nf_stop;
   logic   w_enter, w_both;

   assign w_btn_up  = {1'b0, U3, U2, U1};
   assign w_btn_dn  = {D4, D3, D2, 1'b0};
   assign w_btn_car = {F4, F3, F2, F1};

   assign w_led_up  = {1'b0, w_q[2:0]};
   assign w_led_dn  = {w_q[5:3], 1'b0};
   assign w_led_car = w_q[9:6];

   assign w_here      = floor_onehot(r_floor);
   assign w_door_open = (r_state == DOOR) && (r_cnt != DOOR_LAST);

   // While the door stands open at a floor, calls for that floor are already being served.
   assign w_absorb  = w_door_open ? w_here : 4'b0000;
   assign w_set_up  = w_btn_up  & ~w_absorb;
   assign w_set_dn  = w_btn_dn  & ~w_absorb;
   assign w_set_car = w_btn_car & ~w_absorb;

   // Scheduling sees this cycle's presses too, so a press at a floor where the car is about
   // to stop is cleared on the same edge and its LED never lights.
   assign w_pend_up  = w_led_up  | w_set_up;
   assign w_pend_dn  = w_led_dn  | w_set_dn;
   assign w_pend_car = w_led_car | w_set_car;
   assign w_pend     = w_pend_up | w_pend_dn | w_pend_car;

   assign w_above = |(w_pend & above_mask(r_floor));
   assign w_below = |(w_pend & below_mask(r_floor));

   // Floor the car reaches at the end of the current hop.
   assign w_nf       = (r_dir == DIR_DOWN) ? (r_floor - 2'd1) : (r_floor + 2'd1);
   assign w_nf_ahead = (r_dir == DIR_DOWN) ? |(w_pend & below_mask(w_nf))
                                           : |(w_pend & above_mask(w_nf));
   assign w_nf_edge  = (w_nf == 2'd0) || (w_nf == 2'd3);
   assign w_nf_stop  = w_pend_car[w_nf]
                     | ((r_dir == DIR_UP)   & w_pend_up[w_nf])
                     | ((r_dir == DIR_DOWN) & w_pend_dn[w_nf])
                     | ~w_nf_ahead;

`ifdef ELEVATOR_DOOR_REOPEN_EN
   logic w_reopen;
   assign w_reopen = |((w_btn_up | w_btn_dn | w_btn_car) & w_here);
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= IDLE;
         r_floor <= '0;
         r_dir   <= DIR_IDLE;
         r_cnt   <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_floor <= w_floor_nxt;
         r_dir   <= w_dir_nxt;
         r_cnt   <= w_cnt_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_floor_nxt = r_floor;
      w_dir_nxt   = r_dir;
      w_cnt_nxt   = r_cnt;
      w_enter     = 1'b0;
      w_sf        = r_floor;
      w_both      = 1'b0;
      case (r_state)
         IDLE: begin
            if (|(w_pend & w_here)) begin
               // Idle direction: every call at this floor is served.
               w_enter = 1'b1;
               w_both  = 1'b1;
            end else if (w_above) begin
               w_state_nxt = MOVE;
               w_dir_nxt   = DIR_UP;
               w_cnt_nxt   = '0;
            end else if (w_below) begin
               w_state_nxt = MOVE;
               w_dir_nxt   = DIR_DOWN;
               w_cnt_nxt   = '0;
            end
         end
         MOVE: begin
            if (r_cnt == MOVE_LAST) begin
               w_floor_nxt = w_nf;
               if (w_nf_stop) begin
                  w_enter = 1'b1;
                  w_sf    = w_nf;
                  // At an end floor, or with nothing further ahead, the car turns or idles
                  // after this stop, so the opposite hall call is served here as well.
                  w_both  = w_nf_edge | ~w_nf_ahead;
               end else begin
                  w_cnt_nxt = '0;
               end
            end else begin
               w_cnt_nxt = r_cnt + CW'(1);
            end
         end
         DOOR: begin
            if (r_cnt == DOOR_LAST) begin
               w_cnt_nxt = '0;
               if (r_dir == DIR_DOWN) begin
                  if (w_below) begin
                     w_state_nxt = MOVE;
                     w_dir_nxt   = DIR_DOWN;
                  end else if (w_above) begin
                     w_state_nxt = MOVE;
                     w_dir_nxt   = DIR_UP;
                  end else begin
                     w_state_nxt = IDLE;
                     w_dir_nxt   = DIR_IDLE;
                  end
               end else begin
                  // Up and idle both prefer upward travel.
                  if (w_above) begin
                     w_state_nxt = MOVE;
                     w_dir_nxt   = DIR_UP;
                  end else if (w_below) begin
                     w_state_nxt = MOVE;
                     w_dir_nxt   = DIR_DOWN;
                  end else begin
                     w_state_nxt = IDLE;
                     w_dir_nxt   = DIR_IDLE;
                  end
               end
            end else begin
               w_cnt_nxt = r_cnt + CW'(1);
`ifdef ELEVATOR_DOOR_REOPEN_EN
               if (w_reopen) begin
                  w_cnt_nxt = '0;
               end
`endif
            end
         end
         default: begin
            w_state_nxt = IDLE;
            w_dir_nxt   = DIR_IDLE;
            w_cnt_nxt   = '0;
         end
      endcase
      if (w_enter) begin
         w_state_nxt = DOOR;
         w_cnt_nxt   = '0;
      end
   end

   // Service clear on the edge the car enters DOOR at floor w_sf.
   always_comb begin
      w_oh  = floor_onehot(w_sf);
      w_clr = '0;
      if (w_enter) begin
         w_clr[9:6] = w_oh;
         if (w_both || (r_dir == DIR_UP)) begin
            w_clr[2:0] = w_oh[2:0];
         end
         if (w_both || (r_dir == DIR_DOWN)) begin
            w_clr[5:3] = w_oh[3:1];
         end
      end
   end

   assign w_set = {w_set_car, w_set_dn[3:1], w_set_up[2:0]};

   request_latch #(
      .W(10)
   ) u_req (
      .clk  (clk),
      .rst  (rst),
      .i_set(w_set),
      .i_clr(w_clr),
      .o_q  (w_q)
   );

   assign U1_led = w_q[0];
   assign U2_led = w_q[1];
   assign U3_led = w_q[2];
   assign D2_led = w_q[3];
   assign D3_led = w_q[4];
   assign D4_led = w_q[5];
   assign F1_led = w_q[6];
   assign F2_led = w_q[7];
   assign F3_led = w_q[8];
   assign F4_led = w_q[9];

   assign Floor     = r_floor;
   assign Direction = r_dir;
   assign door_open = w_door_open;
   assign Opened    = (r_state == DOOR) && (r_cnt == DOOR_LAST);

endmodule

// File: tb/tb_elevator.sv
// tb_elevator: randomized + directed stimulus against a behavioural elevator model.
// Door-open and door-close events are queued by the model and checked by a separate monitor.
module tb_elevator;

   localparam int MOVE_CYCLES = 4;
   localparam int DOOR_CYCLES = 3;

   logic       clk = 1'b0;
   logic       rst;
   logic [9:0] btn;   // {F4,F3,F2,F1,D4,D3,D2,U3,U2,U1}

   logic U1_led, U2_led, U3_led, D2_led, D3_led, D4_led;
   logic F1_led, F2_led, F3_led, F4_led;
   logic [1:0] Floor, Direction;
   logic door_open, Opened;
   logic [9:0] dut_leds;

   elevator #(.MOVE_CYCLES(MOVE_CYCLES), .DOOR_CYCLES(DOOR_CYCLES)) dut (
      .clk(clk), .rst(rst),
      .U1(btn[0]), .U2(btn[1]), .U3(btn[2]),
      .D2(btn[3]), .D3(btn[4]), .D4(btn[5]),
      .F1(btn[6]), .F2(btn[7]), .F3(btn[8]), .F4(btn[9]),
      .U1_led(U1_led), .U2_led(U2_led), .U3_led(U3_led),
      .D2_led(D2_led), .D3_led(D3_led), .D4_led(D4_led),
      .F1_led(F1_led), .F2_led(F2_led), .F3_led(F3_led), .F4_led(F4_led),
      .Floor(Floor), .Direction(Direction), .door_open(door_open), .Opened(Opened)
   );

   assign dut_leds = {F4_led, F3_led, F2_led, F1_led, D4_led, D3_led, D2_led, U3_led, U2_led, U1_led};

   always #5 clk = ~clk;

   int n_tests = 0;
   int n_fail  = 0;
   int cyc     = 0;
   bit mon_en  = 1'b0;
   bit mon_prev_open = 1'b0;

   typedef struct {
      int         cyc;
      int         fl;
      int         dir;
      logic [9:0] leds;
   } ev_t;

   ev_t open_q[$];
   ev_t close_q[$];

   // ---------------- behavioural model ----------------
   // mode: 0 idle, 1 travelling, 2 door; left = cycles remaining in the current activity.
   int m_floor, m_dir, m_mode, m_left;
   bit m_up[4], m_dn[4], m_car[4];
   bit p_up[4], p_dn[4], p_car[4];

   function automatic bit req_at(int f);
      return p_up[f] | p_dn[f] | p_car[f];
   endfunction

   function automatic bit beyond(int f, int d);
      for (int g = 0; g < 4; g++) begin
         if (d == 1 && g > f && req_at(g)) return 1'b1;
         if (d == 2 && g < f && req_at(g)) return 1'b1;
      end
      return 1'b0;
   endfunction

   function automatic logic [9:0] model_leds();
      return {m_car[3], m_car[2], m_car[1], m_car[0], m_dn[3], m_dn[2], m_dn[1],
              m_up[2], m_up[1], m_up[0]};
   endfunction

   task automatic model_step(input logic [9:0] b, input logic r);
      bit was_open;
      int stop, fl, first, second;
      bit both;
      ev_t e;
      was_open = (m_mode == 2) && (m_left > 0);
      if (r) begin
         m_floor = 0; m_dir = 0; m_mode = 0; m_left = 0;
         for (int f = 0; f < 4; f++) begin
            m_up[f] = 0; m_dn[f] = 0; m_car[f] = 0;
         end
         return;
      end
      for (int f = 0; f < 4; f++) begin
         p_up[f] = m_up[f]; p_dn[f] = m_dn[f]; p_car[f] = m_car[f];
      end
      for (int k = 0; k < 10; k++) begin
         fl = (k < 3) ? k : ((k < 6) ? k - 2 : k - 6);
         if (b[k] && !(was_open && fl == m_floor)) begin
            if (k < 3) p_up[fl] = 1;
            else if (k < 6) p_dn[fl] = 1;
            else p_car[fl] = 1;
         end
      end
      stop = -1;
      if (m_mode == 0) begin
         if (req_at(m_floor)) stop = m_floor;
         else if (beyond(m_floor, 1)) begin m_mode = 1; m_dir = 1; m_left = MOVE_CYCLES; end
         else if (beyond(m_floor, 2)) begin m_mode = 1; m_dir = 2; m_left = MOVE_CYCLES; end
      end else if (m_mode == 1) begin
         m_left--;
         if (m_left == 0) begin
            m_floor += (m_dir == 1) ? 1 : -1;
            if (p_car[m_floor] || (m_dir == 1 && p_up[m_floor]) || (m_dir == 2 && p_dn[m_floor])
                || !beyond(m_floor, m_dir))
               stop = m_floor;
            else
               m_left = MOVE_CYCLES;
         end
      end else begin
         if (m_left > 0) m_left--;
         else begin
            first  = (m_dir == 2) ? 2 : 1;
            second = 3 - first;
            if (beyond(m_floor, first)) begin m_mode = 1; m_dir = first; m_left = MOVE_CYCLES; end
            else if (beyond(m_floor, second)) begin m_mode = 1; m_dir = second; m_left = MOVE_CYCLES; end
            else begin m_mode = 0; m_dir = 0; end
         end
      end
      if (stop >= 0) begin
         both = (m_dir == 0) || (stop == 0) || (stop == 3) || !beyond(stop, m_dir);
         p_car[stop] = 0;
         if (both || m_dir == 1) p_up[stop] = 0;
         if (both || m_dir == 2) p_dn[stop] = 0;
         m_mode = 2;
         m_left = DOOR_CYCLES;
      end
      for (int f = 0; f < 4; f++) begin
         m_up[f] = p_up[f]; m_dn[f] = p_dn[f]; m_car[f] = p_car[f];
      end
      e.cyc = cyc; e.fl = m_floor; e.dir = m_dir; e.leds = model_leds();
      if (m_mode == 2 && m_left > 0 && !was_open) open_q.push_back(e);
      if (m_mode == 2 && m_left == 0) close_q.push_back(e);
   endtask

   // ---------------- checking ----------------
   task automatic chk(input string name, input int act, input int exp);
      n_tests++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at cycle %0d", name, act, act, exp, exp, cyc);
      end
   endtask

   task automatic fail_event(input string name);
      n_tests++;
      n_fail++;
      $display("FAIL %s at cycle %0d", name, cyc);
   endtask

   always @(negedge clk) begin
      ev_t e;
      if (mon_en) begin
         if (door_open && !mon_prev_open) begin
            if (open_q.size() == 0) fail_event("unexpected_door_open");
            else begin
               e = open_q.pop_front();
               chk("open_cycle", cyc, e.cyc);
               chk("open_floor", int'(Floor), e.fl);
               chk("open_dir", int'(Direction), e.dir);
               chk("open_leds", int'(dut_leds), int'(e.leds));
            end
         end else if (open_q.size() > 0 && open_q[0].cyc <= cyc) begin
            e = open_q.pop_front();
            fail_event("missed_door_open");
         end
         if (Opened) begin
            if (close_q.size() == 0) fail_event("unexpected_opened");
            else begin
               e = close_q.pop_front();
               chk("close_cycle", cyc, e.cyc);
               chk("close_floor", int'(Floor), e.fl);
               chk("close_dir", int'(Direction), e.dir);
               chk("close_leds", int'(dut_leds), int'(e.leds));
               chk("close_door_low", int'(door_open), 0);
            end
         end else if (close_q.size() > 0 && close_q[0].cyc <= cyc) begin
            e = close_q.pop_front();
            fail_event("missed_opened");
         end
      end
      mon_prev_open = door_open;
   end

   // ---------------- stimulus ----------------
   task automatic tick();
      @(posedge clk);
      cyc++;
      model_step(btn, rst);
      #1;
   endtask

   task automatic run(input int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   task automatic chk_reset_outputs(input string name);
      @(negedge clk);
      chk(name, int'({Floor, Direction, door_open, Opened, dut_leds}), 0);
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog_timeout at cycle %0d", cyc);
      $fatal(1, "watchdog");
   end

   initial begin
      btn = '0;
      rst = 1'b1;
      run(2);
      chk_reset_outputs("reset_state");
      rst = 1'b0;
      mon_en = 1'b1;
      run(3);
      chk_reset_outputs("idle_after_reset");

      // U1 at floor 1 while idle: served at once, LED never lights.
      btn[0] = 1'b1; tick(); btn = '0;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         chk("u1_led_never_set", int'(U1_led), 0);
         chk("u1_dir_idle", int'(Direction), 0);
         tick();
      end

      // F2 from floor 1.
      btn[7] = 1'b1; tick(); btn = '0;
      @(negedge clk);
      chk("f2_led_set", int'(F2_led), 1);
      chk("f2_dir_up", int'(Direction), 1);
      run(20);
      @(negedge clk);
      chk("f2_floor", int'(Floor), 1);
      chk("f2_led_clear", int'(F2_led), 0);

      // D3 + D4 together from floor 2.
      btn[4] = 1'b1; btn[5] = 1'b1; tick(); btn = '0;
      run(40);
      @(negedge clk);
      chk("d34_floor", int'(Floor), 2);
      chk("d34_leds", int'({D3_led, D4_led}), 0);
      chk("d34_dir_idle", int'(Direction), 0);

      // F1 + F2 from floor 3: heads down, stops at 2 then 1.
      btn[6] = 1'b1; btn[7] = 1'b1; tick(); btn = '0;
      @(negedge clk);
      chk("f12_dir_down", int'(Direction), 2);
      run(40);
      @(negedge clk);
      chk("f12_floor", int'(Floor), 0);
      chk("f12_leds", int'({F1_led, F2_led}), 0);

      // Reset mid-move with an outstanding call.
      btn[9] = 1'b1; tick(); btn = '0;
      btn[3] = 1'b1; tick(); btn = '0;
      run(3);
      rst = 1'b1; tick();
      chk_reset_outputs("reset_mid_move");
      rst = 1'b0;
      run(5);

      // Random traffic with the occasional reset.
      for (int i = 0; i < 4000; i++) begin
         btn = '0;
         for (int k = 0; k < 10; k++) if ($urandom_range(0, 39) == 0) btn[k] = 1'b1;
         rst = ($urandom_range(0, 1999) == 0);
         tick();
      end
      btn = '0;
      rst = 1'b0;
      run(300);

      @(negedge clk);
      chk("final_floor", int'(Floor), m_floor);
      chk("final_dir", int'(Direction), m_dir);
      chk("final_leds", int'(dut_leds), int'(model_leds()));
      chk("final_door", int'(door_open), int'(m_mode == 2 && m_left > 0));
      chk("final_open_q_empty", open_q.size() + close_q.size(), 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/elevator.md
Name: elevator

Overview:
- Single-car controller for a 4-floor elevator.
- Latches hall calls (up/down) and car calls into request registers that drive indicator LEDs.
- Moves the car one floor at a time using collective (SCAN) scheduling and opens the door at each serviced floor.
- Top-level control block driving car position, direction and door indicators.

Parameters:
- MOVE_CYCLES, 4: clock cycles to travel between adjacent floors (minimum 1).
- DOOR_CYCLES, 3: clock cycles the door stays open per stop (minimum 1).

Ports:
- clk  in  1  system clock, all state on rising edge
- rst  in  1  synchronous, active-high reset
- U1, U2, U3  in  1 each  hall up-call buttons, floors 1-3; level-sampled every cycle
- D2, D3, D4  in  1 each  hall down-call buttons, floors 2-4
- F1, F2, F3, F4  in  1 each  car-call buttons, floors 1-4
- U1_led, U2_led, U3_led  out  1 each  latched up hall-call indicators
- D2_led, D3_led, D4_led  out  1 each  latched down hall-call indicators
- F1_led, F2_led, F3_led, F4_led  out  1 each  latched car-call indicators
- Floor  out  2  current floor; 0 = floor 1 … 3 = floor 4
- Direction  out  2  2'b00 idle, 2'b01 up, 2'b10 down; 2'b11 never driven
- door_open  out  1  high while the door is open
- Opened  out  1  one-cycle pulse on the cycle the door closes after a stop

Behaviour:
- Reset, highest priority: Floor=0, Direction=00, door_open=0, Opened=0, all LEDs=0, state IDLE, timers cleared.
- Request latches:
  - Button high on a rising edge sets its LED register the next cycle.
  - An LED stays set until serviced; releasing the button does not clear it.
  - Service clear happens on the cycle the car enters DOOR at floor f:
    - Fn always clears.
    - The hall call in the current Direction clears.
    - If Direction becomes idle, or f is the top or bottom floor, both hall calls at f clear.
  - A press at f while DOOR is active at f is absorbed: the LED does not set.
- States:
  - IDLE: no door, no motion.
  - MOVE: Direction up or down, counting MOVE_CYCLES.
  - DOOR: counting DOOR_CYCLES.
- IDLE transitions:
  - Any request at the current floor → DOOR next cycle.
  - Else a request above → MOVE up.
  - Else a request below → MOVE down.
  - Up is preferred when requests exist both above and below.
- MOVE:
  - Floor increments or decrements when the counter expires (after MOVE_CYCLES cycles).
  - Then, if the new floor has a car call, or a hall call in the travel direction, or no further requests ahead → DOOR.
  - Otherwise continue.
  - Floor never leaves 0..3.
- DOOR:
  - door_open=1 for exactly DOOR_CYCLES cycles.
  - On the closing cycle: door_open=0 and Opened=1 for one cycle.
  - Next state: requests ahead in current direction → MOVE same direction; else requests behind → MOVE reversed; else IDLE with Direction=00.
- Direction holds during DOOR. Reversal happens only after a door cycle or from IDLE.
- Simultaneous presses are all latched; new requests are accepted during MOVE and DOOR.
- Reset mid-move or mid-door returns the car to floor 1 state immediately (a logical reset, not a travel).

Optional Feature:
- Macro: ELEVATOR_DOOR_REOPEN_EN.
- Defined: in DOOR, any button for the current floor restarts the door counter, extending door_open by DOOR_CYCLES from that cycle. Opened is delayed accordingly.
- Undefined: such presses are absorbed with no timer effect.

Decomposition:
- Package elevator_pkg holds:
  - state enum {IDLE, MOVE, DOOR}
  - direction constants DIR_IDLE=2'b00, DIR_UP=2'b01, DIR_DOWN=2'b10
  - NUM_FLOORS=4
- Sub-module request_latch: one set/clear register per button. It is instantiated 10 times, or once as a 10-bit vector.
- Scheduling and timers stay in the top module.

Test Plan:
- Reset pulse, then idle → Floor=0, Direction=00, door_open=0, Opened=0, all LEDs 0.
- U1 pressed at floor 1 while idle → U1_led never sets; door_open high for 3 cycles, then Opened pulses once; Direction=00.
- F2 pressed at floor 1 → F2_led=1 next cycle, Direction=01; Floor=1 after 4 cycles; door opens; F2_led clears; then IDLE.
- At floor 2, D3 and D4 pressed together → up to floor 4; D4 serviced and cleared first; reverse; stop at floor 3, D3 cleared; Direction=10 then 00.
- F1 and F2 pressed at floor 3 with Direction down → stops at floor 2 then floor 1; each F LED clears on its stop.
- Rst asserted mid-MOVE → next cycle all outputs at reset values, including the LEDs.
